// File: rtl/cnt_wnd_seq.sv
// ============================================================================
// Module   : cnt_wnd_seq (with helper cnt_set)
// Brief    : Time-multiplexed windowed popcount; one CHUNK_WIDTH tree reused
//            per chunk. Optional macro CNT_WND_SEQ_EARLY_EXIT_EN ends COUNT
//            after the last chunk that overlaps the window.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnt_set #(
   parameter int WIDTH       = 32,
   parameter int OUT_WIDTH   = 6,
   parameter int BLOCK_WIDTH = 2
) (
   input  logic [WIDTH-1:0]     vect,
   output logic [OUT_WIDTH-1:0] cnt
);
   localparam int c_num_blk = WIDTH / BLOCK_WIDTH;
   localparam int c_leaf_w  = $clog2(BLOCK_WIDTH) + 1;

   logic [c_leaf_w-1:0] w_blk_cnt [c_num_blk];

   generate
      for (genvar b = 0; b < c_num_blk; b++) begin : g_blk
         assign w_blk_cnt[b] = c_leaf_w'($countones(vect[b*BLOCK_WIDTH +: BLOCK_WIDTH]));
      end
   endgenerate

   always_comb begin
      cnt = '0;
      for (int b = 0; b < c_num_blk; b++) begin
         cnt = cnt + OUT_WIDTH'(w_blk_cnt[b]);
      end
   end
endmodule

module cnt_wnd_seq #(
   parameter int VECT_WIDTH      = 128,
   parameter int CHUNK_WIDTH     = 32,
   parameter int CHUNK_IND_WIDTH = 6,
   parameter int CNT_WIDTH       = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_val,
   output logic                  req_rdy,
   input  logic [VECT_WIDTH-1:0] req_vect,
   input  logic [CNT_WIDTH-1:0]  req_len,
   output logic                  resp_val,
   input  logic                  resp_rdy,
   output logic [CNT_WIDTH-1:0]  resp_cnt,
   output logic                  busy
);
   localparam int c_num_chunks = VECT_WIDTH / CHUNK_WIDTH;
   localparam int c_idx_w      = (c_num_chunks > 1) ? $clog2(c_num_chunks) : 1;
   localparam int c_chunk_sh   = $clog2(CHUNK_WIDTH);

   localparam logic [c_idx_w-1:0]   c_last_idx = c_idx_w'(c_num_chunks - 1);
   localparam logic [CNT_WIDTH-1:0] c_vect_len = CNT_WIDTH'(VECT_WIDTH);

   localparam logic [1:0] c_idle  = 2'd0;
   localparam logic [1:0] c_count = 2'd1;
   localparam logic [1:0] c_resp  = 2'd2;

   logic [1:0]            r_state;
   logic [1:0]            w_next_state;
   logic [VECT_WIDTH-1:0] r_vect;
   logic [CNT_WIDTH-1:0]  r_len;
   logic [CNT_WIDTH-1:0]  r_acc;
   logic [CNT_WIDTH-1:0]  r_resp_cnt;
   logic [c_idx_w-1:0]    r_idx;

   logic [CNT_WIDTH-1:0]       w_len_sat;
   logic [CNT_WIDTH:0]         w_base;
   logic [CHUNK_WIDTH-1:0]     w_chunk;
   logic [CHUNK_WIDTH-1:0]     w_mask;
   logic [CHUNK_IND_WIDTH-1:0] w_chunk_cnt;
   logic [CNT_WIDTH-1:0]       w_sum;
   logic                       w_last;

   assign w_len_sat = (req_len > c_vect_len) ? c_vect_len : req_len;
   assign w_base    = (CNT_WIDTH+1)'(r_idx) << c_chunk_sh;
   assign w_chunk   = r_vect[int'(r_idx)*CHUNK_WIDTH +: CHUNK_WIDTH];

   // Mask keeps only global bit positions strictly below the captured length.
   always_comb begin
      w_mask = '0;
      for (int i = 0; i < CHUNK_WIDTH; i++) begin
         w_mask[i] = (w_base + (CNT_WIDTH+1)'(i)) < {1'b0, r_len};
      end
   end

   cnt_set #(
      .WIDTH       (CHUNK_WIDTH),
      .OUT_WIDTH   (CHUNK_IND_WIDTH),
      .BLOCK_WIDTH (2)
   ) u_cnt_set (
      .vect (w_chunk & w_mask),
      .cnt  (w_chunk_cnt)
   );

   assign w_sum = r_acc + CNT_WIDTH'(w_chunk_cnt);

`ifdef CNT_WND_SEQ_EARLY_EXIT_EN
   // Stop once no later chunk can contain an index below the length.
   assign w_last = ((w_base + (CNT_WIDTH+1)'(CHUNK_WIDTH)) >= {1'b0, r_len}) ||
                   (r_idx == c_last_idx);
`else
   assign w_last = (r_idx == c_last_idx);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_idle;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = c_idle;
      case (r_state)
         c_idle:  w_next_state = req_val  ? c_count : c_idle;
         c_count: w_next_state = w_last   ? c_resp  : c_count;
         c_resp:  w_next_state = resp_rdy ? c_idle  : c_resp;
         default: w_next_state = c_idle;
      endcase
   end

   always_comb begin
      req_rdy  = 1'b0;
      resp_val = 1'b0;
      busy     = 1'b0;
      case (r_state)
         c_idle:  req_rdy = 1'b1;
         c_count: busy = 1'b1;
         c_resp: begin
            resp_val = 1'b1;
            busy     = 1'b1;
         end
         default: req_rdy = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vect     <= '0;
         r_len      <= '0;
         r_acc      <= '0;
         r_idx      <= '0;
         r_resp_cnt <= '0;
      end else begin
         case (r_state)
            c_idle: begin
               if (req_val) begin
                  r_vect <= req_vect;
                  r_len  <= w_len_sat;
                  r_acc  <= '0;
                  r_idx  <= '0;
               end
            end
            c_count: begin
               r_acc <= w_sum;
               r_idx <= r_idx + 1'b1;
               if (w_last) begin
                  r_resp_cnt <= w_sum;
               end
            end
            default: begin
               r_acc <= r_acc;
            end
         endcase
      end
   end

   assign resp_cnt = r_resp_cnt;
endmodule

`default_nettype wire

// File: tb/tb_cnt_wnd_seq.sv
// ============================================================================
// Module   : tb_cnt_wnd_seq
// Brief    : Self-checking bench for cnt_wnd_seq; transaction-level model plus
//            directed literal cases and randomized requests.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cnt_wnd_seq;
   localparam int VW  = 128;
   localparam int CW  = 32;
   localparam int CIW = 6;
   localparam int CNW = 8;
   localparam int NC  = VW / CW;

`ifdef CNT_WND_SEQ_EARLY_EXIT_EN
   localparam int LAT40 = 2;
   localparam int LAT0  = 1;
   localparam int LAT1  = 1;
`else
   localparam int LAT40 = NC;
   localparam int LAT0  = NC;
   localparam int LAT1  = NC;
`endif

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           req_val = 1'b0;
   logic           resp_rdy = 1'b0;
   logic [VW-1:0]  req_vect = '0;
   logic [CNW-1:0] req_len = '0;
   logic           req_rdy;
   logic           resp_val;
   logic [CNW-1:0] resp_cnt;
   logic           busy;

   int checks = 0;
   int errors = 0;

   cnt_wnd_seq #(
      .VECT_WIDTH      (VW),
      .CHUNK_WIDTH     (CW),
      .CHUNK_IND_WIDTH (CIW),
      .CNT_WIDTH       (CNW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_val  (req_val),
      .req_rdy  (req_rdy),
      .req_vect (req_vect),
      .req_len  (req_len),
      .resp_val (resp_val),
      .resp_rdy (resp_rdy),
      .resp_cnt (resp_cnt),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int ref_cnt(input logic [VW-1:0] v, input int len);
      int l = (len > VW) ? VW : len;
      int c = 0;
      for (int i = 0; i < l; i++) c += int'(v[i]);
      return c;
   endfunction

   function automatic int ref_lat(input int len);
`ifdef CNT_WND_SEQ_EARLY_EXIT_EN
      int l = (len > VW) ? VW : len;
      return (l == 0) ? 1 : (l + CW - 1) / CW;
`else
      return (len >= 0) ? NC : NC;
`endif
   endfunction

   // Transaction model: cycles left until response, pending response, result.
   int m_left = 0;
   bit m_resp = 1'b0;
   int m_cnt  = 0;
   int m_pend = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_left = 0;
         m_resp = 1'b0;
         m_cnt  = 0;
         m_pend = 0;
      end else if (m_left > 0) begin
         m_left = m_left - 1;
         if (m_left == 0) begin
            m_resp = 1'b1;
            m_cnt  = m_pend;
         end
      end else if (m_resp) begin
         if (resp_rdy) m_resp = 1'b0;
      end else if (req_val) begin
         m_pend = ref_cnt(req_vect, int'(req_len));
         m_left = ref_lat(int'(req_len));
      end
   end

   always @(negedge clk) begin
      check("req_rdy",  {31'd0, req_rdy},  {31'd0, (m_left == 0 && !m_resp)});
      check("busy",     {31'd0, busy},     {31'd0, (m_left != 0 || m_resp)});
      check("resp_val", {31'd0, resp_val}, {31'd0, m_resp});
      check("resp_cnt", {24'd0, resp_cnt}, m_cnt);
   end

   task automatic do_req(input logic [VW-1:0] v, input logic [CNW-1:0] l,
                         input logic [VW-1:0] post_v, input int stall,
                         input bit lit, input int exp_cnt, input int exp_lat);
      int n;
      int lat;
      n = 0;
      while (!req_rdy && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("req_rdy_wait", {31'd0, req_rdy}, 32'd1);
      req_val  = 1'b1;
      req_vect = v;
      req_len  = l;
      resp_rdy = (stall == 0);
      @(negedge clk);
      req_val  = 1'b0;
      req_vect = post_v;
      req_len  = CNW'($urandom);
      lat = 0;
      while (!resp_val && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("resp_seen", {31'd0, resp_val}, 32'd1);
      if (lit) begin
         check("latency", lat, exp_lat);
         check("result",  {24'd0, resp_cnt}, exp_cnt);
      end
      for (int i = 0; i < stall; i++) begin
         if (lit) begin
            check("stall_cnt",  {24'd0, resp_cnt}, exp_cnt);
            check("stall_rdy",  {31'd0, req_rdy},  32'd0);
            check("stall_busy", {31'd0, busy},     32'd1);
         end
         @(negedge clk);
      end
      resp_rdy = 1'b1;
      @(negedge clk);
      resp_rdy = 1'b0;
      if (lit) begin
         check("post_rdy", {31'd0, req_rdy},  32'd1);
         check("post_val", {31'd0, resp_val}, 32'd0);
         check("post_cnt", {24'd0, resp_cnt}, exp_cnt);
      end
   endtask

   initial begin
      logic [VW-1:0] ones;
      logic [VW-1:0] pat_a;
      logic [VW-1:0] rv;
      ones  = '1;
      pat_a = {32{4'hA}};
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_req_rdy",  {31'd0, req_rdy},  32'd1);
      check("rst_resp_val", {31'd0, resp_val}, 32'd0);
      check("rst_resp_cnt", {24'd0, resp_cnt}, 32'd0);
      check("rst_busy",     {31'd0, busy},     32'd0);

      do_req(ones, 8'd128, ones, 0, 1'b1, 128, NC);
      do_req(ones, 8'd40,  ones, 0, 1'b1, 40,  LAT40);
      do_req(pat_a, 8'd128, pat_a, 5, 1'b1, 64, NC);
      do_req(ones, 8'd200, ones, 0, 1'b1, 128, NC);
      do_req(ones, 8'd0,   ones, 0, 1'b1, 0,   LAT0);
      do_req(ones, 8'd128, '0,   0, 1'b1, 128, NC);

      // Abort a request two edges into COUNT with an asynchronous reset.
      req_val  = 1'b1;
      req_vect = ones;
      req_len  = 8'd128;
      @(negedge clk);
      req_val = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_req_rdy",  {31'd0, req_rdy},  32'd1);
      check("abort_resp_val", {31'd0, resp_val}, 32'd0);
      check("abort_busy",     {31'd0, busy},     32'd0);
      @(negedge clk);
      rst = 1'b0;
      do_req({{(VW-1){1'b0}}, 1'b1}, 8'd1, ones, 0, 1'b1, 1, LAT1);

      for (int k = 0; k < 40; k++) begin
         rv = {$urandom, $urandom, $urandom, $urandom};
         do_req(rv, CNW'($urandom_range(0, 200)),
                {$urandom, $urandom, $urandom, $urandom},
                int'($urandom_range(0, 3)), 1'b0, 0, 0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire
